// File: rtl/roce_stack_xlate_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : roce_stack_xlate_arbiter (with package roce_xlate_arb_pkg)
//  Purpose  : Shares one virtual-to-physical translation port between
//             NUM_REQ request handlers. Requests are granted round-robin
//             into a registered slot. The requester ID of every issued
//             request is kept in an order FIFO, and in-order responses are
//             steered back to the requester that issued them.
//  Ports    : clk_i, aresetn_i        clock, async active-low reset
//             s_req_*                  per-requester request (valid/ready/vaddr/qpn)
//             m_req_*                  request to the translation table
//             m_resp_*                 response from the translation table
//             s_resp_*                 per-requester response (data shared)
//             outstanding_o            order-FIFO occupancy
//             timeout_o                sticky watchdog flag
//  Options  : ROCE_XLATE_ARB_WATCHDOG_EN builds the response watchdog;
//             without it timeout_o is tied to 0.
//  Revision : 1.0  initial release
// ============================================================================

package roce_xlate_arb_pkg;
  typedef struct packed {
    logic [63:0] paddr;
    logic [31:0] buflen;
    logic [31:0] accesdesc;
  } dma_req_t;
endpackage

module roce_stack_xlate_arbiter
  import roce_xlate_arb_pkg::*;
#(
  parameter int NUM_REQ         = 2,
  parameter int MAX_OUTSTANDING = 4,
  parameter int TIMEOUT_CYCLES  = 1024
) (
  input  logic                                clk_i,
  input  logic                                aresetn_i,
  input  logic [NUM_REQ-1:0]                  s_req_valid_i,
  output logic [NUM_REQ-1:0]                  s_req_ready_o,
  input  logic [NUM_REQ-1:0][63:0]            s_req_vaddr_i,
  input  logic [NUM_REQ-1:0][15:0]            s_req_qpn_i,
  output logic                                m_req_valid_o,
  input  logic                                m_req_ready_i,
  output logic [63:0]                         m_req_vaddr_o,
  output logic [15:0]                         m_req_qpn_o,
  input  logic                                m_resp_valid_i,
  output logic                                m_resp_ready_o,
  input  dma_req_t                            m_resp_data_i,
  output logic [NUM_REQ-1:0]                  s_resp_valid_o,
  input  logic [NUM_REQ-1:0]                  s_resp_ready_i,
  output dma_req_t                            s_resp_data_o,
  output logic [$clog2(MAX_OUTSTANDING):0]    outstanding_o,
  output logic                                timeout_o
);

  localparam int c_ID_W  = $clog2(NUM_REQ);
  localparam int c_PTR_W = $clog2(MAX_OUTSTANDING);
  localparam int c_CNT_W = c_PTR_W + 1;

  typedef enum logic [0:0] {
    ARB_IDLE = 1'b0,
    ARB_HOLD = 1'b1
  } arb_state_t;

  arb_state_t          r_state;
  arb_state_t          w_state_nxt;
  logic [c_ID_W-1:0]   r_rr_ptr;
  logic [c_ID_W-1:0]   r_slot_id;
  logic [63:0]         r_slot_vaddr;
  logic [15:0]         r_slot_qpn;

  logic [c_ID_W-1:0]   r_fifo [MAX_OUTSTANDING];
  logic [c_PTR_W-1:0]  r_wr_ptr;
  logic [c_PTR_W-1:0]  r_rd_ptr;
  logic [c_CNT_W-1:0]  r_count;

  logic                w_gnt_found;
  logic [c_ID_W-1:0]   w_gnt_id;
  logic                w_grant;
  logic                w_push;
  logic                w_pop;
  logic                w_full;
  logic                w_nonempty;
  logic [c_ID_W-1:0]   w_head;

  assign w_full     = (r_count == c_CNT_W'(MAX_OUTSTANDING));
  assign w_nonempty = (r_count != '0);
  assign w_head     = r_fifo[r_rd_ptr];
  assign w_push     = (r_state == ARB_HOLD) && m_req_ready_i;
  assign w_pop      = m_resp_valid_i && m_resp_ready_o;

  // Cyclic priority search starting at the round-robin pointer.
  always_comb begin
    int w_idx;
    w_gnt_found = 1'b0;
    w_gnt_id    = '0;
    w_idx       = 0;
    for (int i = 0; i < NUM_REQ; i++) begin
      w_idx = int'(r_rr_ptr) + i;
      if (w_idx >= NUM_REQ) w_idx = w_idx - NUM_REQ;
      if (!w_gnt_found && s_req_valid_i[w_idx]) begin
        w_gnt_found = 1'b1;
        w_gnt_id    = w_idx[c_ID_W-1:0];
      end
    end
  end

  // Request-side FSM: next state and grant strobe.
  always_comb begin
    w_state_nxt   = r_state;
    s_req_ready_o = '0;
    w_grant       = 1'b0;
    case (r_state)
      ARB_IDLE: begin
        if (w_gnt_found && !w_full) begin
          s_req_ready_o[w_gnt_id] = 1'b1;
          w_grant                 = 1'b1;
          w_state_nxt             = ARB_HOLD;
        end
      end
      ARB_HOLD: begin
        if (m_req_ready_i) w_state_nxt = ARB_IDLE;
      end
      default: w_state_nxt = ARB_IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge aresetn_i) begin
    if (!aresetn_i) begin
      r_state      <= ARB_IDLE;
      r_rr_ptr     <= '0;
      r_slot_id    <= '0;
      r_slot_vaddr <= '0;
      r_slot_qpn   <= '0;
    end else begin
      r_state <= w_state_nxt;
      if (w_grant) begin
        r_slot_id    <= w_gnt_id;
        r_slot_vaddr <= s_req_vaddr_i[w_gnt_id];
        r_slot_qpn   <= s_req_qpn_i[w_gnt_id];
        r_rr_ptr     <= (w_gnt_id == c_ID_W'(NUM_REQ - 1)) ? '0 : w_gnt_id + 1'b1;
      end
    end
  end

  assign m_req_valid_o = (r_state == ARB_HOLD);
  assign m_req_vaddr_o = r_slot_vaddr;
  assign m_req_qpn_o   = r_slot_qpn;

  // Order FIFO. Pointers wrap naturally because the depth is a power of 2;
  // the count cannot exceed the depth since grants stop when full.
  always_ff @(posedge clk_i or negedge aresetn_i) begin
    if (!aresetn_i) begin
      for (int i = 0; i < MAX_OUTSTANDING; i++) r_fifo[i] <= '0;
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) begin
        r_fifo[r_wr_ptr] <= r_slot_id;
        r_wr_ptr         <= r_wr_ptr + 1'b1;
      end
      if (w_pop) r_rd_ptr <= r_rd_ptr + 1'b1;
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  assign outstanding_o = r_count;

  // Response steering: an empty FIFO blocks stray responses entirely.
  always_comb begin
    s_resp_valid_o = '0;
    if (m_resp_valid_i && w_nonempty) s_resp_valid_o[w_head] = 1'b1;
  end

  assign m_resp_ready_o = w_nonempty && s_resp_ready_i[w_head];
  assign s_resp_data_o  = m_resp_data_i;

`ifdef ROCE_XLATE_ARB_WATCHDOG_EN
  logic [31:0] r_wd_cnt;
  logic        r_timeout;

  // Counts cycles spent waiting on the head response; saturates at the limit.
  always_ff @(posedge clk_i or negedge aresetn_i) begin
    if (!aresetn_i) begin
      r_wd_cnt  <= '0;
      r_timeout <= 1'b0;
    end else begin
      if (!w_nonempty || w_pop) begin
        r_wd_cnt <= '0;
      end else if (r_wd_cnt != 32'(TIMEOUT_CYCLES)) begin
        r_wd_cnt <= r_wd_cnt + 32'd1;
        if (r_wd_cnt == 32'(TIMEOUT_CYCLES - 1)) r_timeout <= 1'b1;
      end
    end
  end

  assign timeout_o = r_timeout;
`else
  logic w_unused_timeout_cfg;
  assign w_unused_timeout_cfg = ^32'(TIMEOUT_CYCLES);
  assign timeout_o            = 1'b0;
`endif

endmodule

`default_nettype wire

// File: tb/tb_roce_stack_xlate_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : tb_roce_stack_xlate_arbiter
//  Purpose  : Directed scoreboard bench for roce_stack_xlate_arbiter.
//             Stimulus pushes expected issues/responses into queues; a
//             negedge monitor pops and compares on every handshake.
//  Revision : 1.0  initial release
// ============================================================================
module tb_roce_stack_xlate_arbiter;
  import roce_xlate_arb_pkg::*;

  localparam int NREQ = 2;
  localparam int MAXO = 4;
  localparam int TMO  = 16;
`ifdef ROCE_XLATE_ARB_WATCHDOG_EN
  localparam bit WD_EN = 1'b1;
`else
  localparam bit WD_EN = 1'b0;
`endif

  logic                   clk_i = 1'b0;
  logic                   aresetn_i;
  logic [NREQ-1:0]        s_req_valid_i;
  logic [NREQ-1:0]        s_req_ready_o;
  logic [NREQ-1:0][63:0]  s_req_vaddr_i;
  logic [NREQ-1:0][15:0]  s_req_qpn_i;
  logic                   m_req_valid_o;
  logic                   m_req_ready_i;
  logic [63:0]            m_req_vaddr_o;
  logic [15:0]            m_req_qpn_o;
  logic                   m_resp_valid_i;
  logic                   m_resp_ready_o;
  dma_req_t               m_resp_data_i;
  logic [NREQ-1:0]        s_resp_valid_o;
  logic [NREQ-1:0]        s_resp_ready_i;
  dma_req_t               s_resp_data_o;
  logic [2:0]             outstanding_o;
  logic                   timeout_o;

  roce_stack_xlate_arbiter #(
    .NUM_REQ(NREQ), .MAX_OUTSTANDING(MAXO), .TIMEOUT_CYCLES(TMO)
  ) dut (
    .clk_i(clk_i), .aresetn_i(aresetn_i),
    .s_req_valid_i(s_req_valid_i), .s_req_ready_o(s_req_ready_o),
    .s_req_vaddr_i(s_req_vaddr_i), .s_req_qpn_i(s_req_qpn_i),
    .m_req_valid_o(m_req_valid_o), .m_req_ready_i(m_req_ready_i),
    .m_req_vaddr_o(m_req_vaddr_o), .m_req_qpn_o(m_req_qpn_o),
    .m_resp_valid_i(m_resp_valid_i), .m_resp_ready_o(m_resp_ready_o),
    .m_resp_data_i(m_resp_data_i),
    .s_resp_valid_o(s_resp_valid_o), .s_resp_ready_i(s_resp_ready_i),
    .s_resp_data_o(s_resp_data_o),
    .outstanding_o(outstanding_o), .timeout_o(timeout_o)
  );

  always #5 clk_i = ~clk_i;

  typedef struct { logic [63:0] vaddr; logic [15:0] qpn; } req_exp_t;
  typedef struct { int id; dma_req_t data; } resp_exp_t;

  req_exp_t  exp_req[$];
  resp_exp_t exp_resp[$];

  int n_pass  = 0;
  int n_total = 0;

  function automatic void chk(string name, logic [127:0] act, logic [127:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
  endfunction

  function automatic dma_req_t mk(logic [63:0] pa, logic [31:0] bl);
    dma_req_t d;
    d.paddr = pa; d.buflen = bl; d.accesdesc = 32'hA5A5_0000 | bl;
    return d;
  endfunction

  // Monitor: inputs are stable between the #1 drive point and the next
  // posedge, so at negedge valid&ready means a handshake at the coming edge.
  always @(negedge clk_i) begin
    if (aresetn_i) begin
      if (m_req_valid_o && m_req_ready_i) begin
        if (exp_req.size() == 0) chk("req_unexpected", 1, 0);
        else begin
          req_exp_t e;
          e = exp_req.pop_front();
          chk("req_vaddr", m_req_vaddr_o, e.vaddr);
          chk("req_qpn", m_req_qpn_o, e.qpn);
        end
      end
      if ((s_resp_valid_o & s_resp_ready_i) != '0) begin
        if (exp_resp.size() == 0) chk("resp_unexpected", 1, 0);
        else begin
          resp_exp_t r;
          logic [NREQ-1:0] oh;
          r  = exp_resp.pop_front();
          oh = '0;
          oh[r.id] = 1'b1;
          chk("resp_route", s_resp_valid_o, oh);
          chk("resp_data", s_resp_data_o, r.data);
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic send_resp(dma_req_t d);
    bit ok;
    ok = 1'b0;
    m_resp_valid_i = 1'b1;
    m_resp_data_i  = d;
    #1;
    for (int k = 0; k < 50 && !ok; k++) begin
      if (m_resp_ready_o) ok = 1'b1;
      tick();
    end
    m_resp_valid_i = 1'b0;
    chk("resp_handshake", ok, 1);
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1);
  end

  initial begin
    int gids[4];
    int ng;
    aresetn_i      = 1'b0;
    s_req_valid_i  = '0;
    s_req_vaddr_i  = '0;
    s_req_qpn_i    = '0;
    m_req_ready_i  = 1'b0;
    m_resp_valid_i = 1'b0;
    m_resp_data_i  = '0;
    s_resp_ready_i = '1;
    repeat (3) tick();

    // Reset state
    chk("rst_req_ready", s_req_ready_o, 0);
    chk("rst_m_req_valid", m_req_valid_o, 0);
    chk("rst_vaddr", m_req_vaddr_o, 0);
    chk("rst_qpn", m_req_qpn_o, 0);
    chk("rst_outstanding", outstanding_o, 0);
    chk("rst_timeout", timeout_o, 0);
    aresetn_i = 1'b1;
    tick();

    // Single request from requester 1
    s_req_valid_i[1] = 1'b1;
    s_req_vaddr_i[1] = 64'h1000_0000;
    s_req_qpn_i[1]   = 16'h11;
    exp_req.push_back('{64'h1000_0000, 16'h11});
    #1;
    chk("single_grant", s_req_ready_o, 2'b10);
    tick();
    s_req_valid_i = '0;
    #1;
    chk("single_m_valid", m_req_valid_o, 1);
    chk("single_vaddr", m_req_vaddr_o, 64'h1000_0000);
    chk("single_qpn", m_req_qpn_o, 16'h11);
    chk("hold_no_ready", s_req_ready_o, 0);
    tick(); tick();
    chk("hold_stable_valid", m_req_valid_o, 1);
    chk("hold_stable_vaddr", m_req_vaddr_o, 64'h1000_0000);
    m_req_ready_i = 1'b1;
    tick();
    m_req_ready_i = 1'b0;
    #1;
    chk("single_issued_idle", m_req_valid_o, 0);
    chk("single_outstanding", outstanding_o, 1);
    exp_resp.push_back('{1, mk(64'h8000_0000, 32'h100)});
    m_resp_valid_i = 1'b1;
    m_resp_data_i  = mk(64'h8000_0000, 32'h100);
    #1;
    chk("single_resp_route", s_resp_valid_o, 2'b10);
    send_resp(mk(64'h8000_0000, 32'h100));
    chk("single_drained", outstanding_o, 0);

    // Round-robin: both requesters continuously, table always ready
    m_req_ready_i    = 1'b1;
    s_req_vaddr_i[0] = 64'h2000; s_req_qpn_i[0] = 16'h20;
    s_req_vaddr_i[1] = 64'h3000; s_req_qpn_i[1] = 16'h31;
    for (int i = 0; i < 2; i++) begin
      exp_req.push_back('{64'h2000, 16'h20});
      exp_req.push_back('{64'h3000, 16'h31});
    end
    s_req_valid_i = 2'b11;
    #1;
    ng = 0;
    for (int k = 0; k < 40 && ng < 4; k++) begin
      if (s_req_ready_o != '0) begin
        gids[ng] = (s_req_ready_o == 2'b10) ? 1 : 0;
        ng++;
      end
      tick();
    end
    s_req_valid_i = '0;
    chk("rr_grant0", gids[0], 0);
    chk("rr_grant1", gids[1], 1);
    chk("rr_grant2", gids[2], 0);
    chk("rr_grant3", gids[3], 1);
    tick();
    chk("rr_outstanding", outstanding_o, 4);
    for (int i = 0; i < 4; i++) begin
      exp_resp.push_back('{i % 2, mk(64'h8000_1000 + 64'(i), 32'(i))});
      send_resp(mk(64'h8000_1000 + 64'(i), 32'(i)));
    end
    chk("rr_drained", outstanding_o, 0);

    // FIFO full: requester 0 only, no responses
    s_req_vaddr_i[0] = 64'h4000; s_req_qpn_i[0] = 16'h40;
    for (int i = 0; i < 5; i++) exp_req.push_back('{64'h4000, 16'h40});
    s_req_valid_i = 2'b01;
    #1;
    ng = 0;
    for (int k = 0; k < 20; k++) begin
      if (s_req_ready_o != '0) ng++;
      tick();
    end
    chk("full_issue_count", ng, 4);
    chk("full_no_ready", s_req_ready_o, 0);
    chk("full_outstanding", outstanding_o, 4);
    exp_resp.push_back('{0, mk(64'h9000, 32'h9)});
    send_resp(mk(64'h9000, 32'h9));
    ng = 0;
    for (int k = 0; k < 10; k++) begin
      if (s_req_ready_o != '0) ng++;
      tick();
    end
    s_req_valid_i = '0;
    chk("full_one_regrant", ng, 1);
    chk("full_refilled", outstanding_o, 4);
    for (int i = 0; i < 4; i++) begin
      exp_resp.push_back('{0, mk(64'h9100 + 64'(i), 32'h10 + 32'(i))});
      send_resp(mk(64'h9100 + 64'(i), 32'h10 + 32'(i)));
    end
    chk("full_drained", outstanding_o, 0);

    // Response backpressure: head requester 1 not ready for 5 cycles
    s_req_vaddr_i[1] = 64'h5000; s_req_qpn_i[1] = 16'h51;
    exp_req.push_back('{64'h5000, 16'h51});
    s_req_valid_i = 2'b10;
    #1;
    chk("bp_grant", s_req_ready_o, 2'b10);
    tick();
    s_req_valid_i = '0;
    tick();
    chk("bp_outstanding", outstanding_o, 1);
    s_resp_ready_i = 2'b01;
    m_resp_valid_i = 1'b1;
    m_resp_data_i  = mk(64'hBEEF_0000, 32'h77);
    #1;
    for (int k = 0; k < 5; k++) begin
      chk("bp_m_ready_low", m_resp_ready_o, 0);
      chk("bp_s_valid", s_resp_valid_o, 2'b10);
      tick();
    end
    chk("bp_no_pop", outstanding_o, 1);
    s_resp_ready_i = 2'b11;
    exp_resp.push_back('{1, mk(64'hBEEF_0000, 32'h77)});
    send_resp(mk(64'hBEEF_0000, 32'h77));
    chk("bp_drained", outstanding_o, 0);

    // Stray response with empty FIFO
    m_resp_valid_i = 1'b1;
    m_resp_data_i  = mk(64'hDEAD, 32'h1);
    #1;
    chk("stray_m_ready", m_resp_ready_o, 0);
    chk("stray_s_valid", s_resp_valid_o, 0);
    tick();
    chk("stray_outstanding", outstanding_o, 0);
    m_resp_valid_i = 1'b0;

    // Reset while holding a request (table not ready)
    m_req_ready_i    = 1'b0;
    s_req_vaddr_i[0] = 64'h6000; s_req_qpn_i[0] = 16'h60;
    s_req_valid_i    = 2'b01;
    tick();
    s_req_valid_i = '0;
    #1;
    chk("hold_before_reset", m_req_valid_o, 1);
    aresetn_i = 1'b0;
    #1;
    chk("mid_rst_m_valid", m_req_valid_o, 0);
    chk("mid_rst_vaddr", m_req_vaddr_o, 0);
    chk("mid_rst_qpn", m_req_qpn_o, 0);
    chk("mid_rst_req_ready", s_req_ready_o, 0);
    chk("mid_rst_outstanding", outstanding_o, 0);
    chk("mid_rst_timeout", timeout_o, 0);
    tick();
    aresetn_i = 1'b1;
    tick();

    // Watchdog: one outstanding request, no response
    m_req_ready_i    = 1'b1;
    s_req_vaddr_i[0] = 64'h7000; s_req_qpn_i[0] = 16'h70;
    exp_req.push_back('{64'h7000, 16'h70});
    s_req_valid_i = 2'b01;
    tick();
    s_req_valid_i = '0;
    tick();
    m_req_ready_i = 1'b0;
    chk("wd_outstanding", outstanding_o, 1);
    repeat (15) tick();
    chk("wd_before_limit", timeout_o, 0);
    tick();
    chk("wd_at_limit", timeout_o, WD_EN);
    exp_resp.push_back('{0, mk(64'h7777, 32'h7)});
    send_resp(mk(64'h7777, 32'h7));
    tick();
    chk("wd_sticky", timeout_o, WD_EN);

    repeat (3) tick();
    chk("req_queue_empty", exp_req.size(), 0);
    chk("resp_queue_empty", exp_resp.size(), 0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/roce_stack_xlate_arbiter.md
# roce_stack_xlate_arbiter

Shares the single virtual-to-physical address-translation port of the RoCE stack wrapper between `NUM_REQ` request handlers (read, write, and any later additions). It arbitrates translation requests round-robin and holds one in a registered request slot. It records the requester ID of every issued request in an order FIFO and steers the in-order translation responses back to the originating handler. It sits between the request handlers' `req_addr_*`/`resp_addr_*` ports and the translation table.

## Interface
Parameters:
- `NUM_REQ`, default 2: number of requesters; index 0 is the read handler, index 1 the write handler; legal range 2..8.
- `MAX_OUTSTANDING`, default 4: order-FIFO depth, i.e. the maximum number of issued requests that have not yet received a response; must be a power of 2.
- `TIMEOUT_CYCLES`, default 1024: watchdog limit; used only when the watchdog is compiled in.

Ports:
- `clk_i`  in  1  the single clock.
- `aresetn_i`  in  1  asynchronous, active-low reset.
- `s_req_valid_i`  in  NUM_REQ  per-requester translation request valid.
- `s_req_ready_o`  out  NUM_REQ  per-requester request accept.
- `s_req_vaddr_i`  in  NUM_REQ×64  per-requester virtual address.
- `s_req_qpn_i`  in  NUM_REQ×16  per-requester QPN.
- `m_req_valid_o`  out  1  request valid to the translation table.
- `m_req_ready_i`  in  1  translation table accepts the request.
- `m_req_vaddr_o`  out  64  registered vaddr.
- `m_req_qpn_o`  out  16  registered QPN.
- `m_resp_valid_i`  in  1  translation response valid (responses arrive in issue order).
- `m_resp_ready_o`  out  1  response accept.
- `m_resp_data_i`  in  dma_req_t  response carrying paddr, buflen and accesdesc.
- `s_resp_valid_o`  out  NUM_REQ  per-requester response valid; at most one bit is set at a time.
- `s_resp_ready_i`  in  NUM_REQ  per-requester response accept.
- `s_resp_data_o`  out  dma_req_t  response data, shared by all requesters.
- `outstanding_o`  out  $clog2(MAX_OUTSTANDING)+1  current order-FIFO occupancy.
- `timeout_o`  out  1  sticky watchdog flag.

## Operation
- The request side has two states, `ARB_IDLE` and `ARB_HOLD`.
- **ARB_IDLE:** if any bit of `s_req_valid_i` is set and the order FIFO is not full, the block grants the first requesting index at or after `rr_ptr`, cyclically.
  - `s_req_ready_o[g]` = 1 for that cycle only.
  - The block captures the granted vaddr and QPN into the slot and stores `g` as `slot_id`.
  - The state moves to `ARB_HOLD`.
  - `rr_ptr` ← `(g+1) mod NUM_REQ`.
- **ARB_HOLD:** `m_req_valid_o` = 1 and the slot contents stay stable.
  - On `m_req_ready_i`, the block pushes `slot_id` into the order FIFO and returns to `ARB_IDLE`.
  - No new grant is made in the cycle of that handshake, so the maximum request throughput is one per 2 cycles.
- **FIFO full:** no grant is made and all `s_req_ready_o` bits are 0. A request already held in `ARB_HOLD` is always issuable, because the FIFO was checked at grant time.
- **Response path:** combinational pass-through.
  - `h` = FIFO head.
  - `s_resp_valid_o[h]` = `m_resp_valid_i` AND FIFO not empty.
  - `s_resp_data_o` = `m_resp_data_i`.
  - `m_resp_ready_o` = FIFO not empty AND `s_resp_ready_i[h]`.
  - The FIFO pops on the `m_resp_valid_i & m_resp_ready_o` handshake.
- **Empty FIFO:** `m_resp_ready_o` = 0 and all `s_resp_valid_o` bits are 0. A stray response is never acknowledged.
- **Simultaneous push and pop** in the same cycle: occupancy is unchanged and the FIFO pointers wrap modulo `MAX_OUTSTANDING`.
- `outstanding_o` is the registered FIFO count, saturating at `MAX_OUTSTANDING`.

## Timing
- **Reset values:** `s_req_ready_o` = 0, `m_req_valid_o` = 0, `m_req_vaddr_o` = 0, `m_req_qpn_o` = 0, `rr_ptr` = 0, FIFO empty, `outstanding_o` = 0, `timeout_o` = 0, state `ARB_IDLE`.
- Reset asserted mid-operation discards the held slot and all routing entries. Responses still in flight afterwards are blocked because the FIFO is empty.
- **Request latency:** `s_req_valid_i` high in cycle N (with the block idle) gives `s_req_ready_o` in cycle N and `m_req_valid_o` in cycle N+1.
- **Response latency:** 0 cycles (combinational).
- `m_req_valid_o` never deasserts before its handshake. `s_req_ready_o` never asserts while in `ARB_HOLD`.

## Configuration
- **`ROCE_XLATE_ARB_WATCHDOG_EN` defined:**
  - A 32-bit counter increments every cycle that the FIFO is non-empty and no response handshake occurs.
  - The counter clears on any response handshake or when the FIFO is empty.
  - When the counter reaches `TIMEOUT_CYCLES`, `timeout_o` sets and stays set until reset. Traffic is unaffected.
- **Macro undefined:** no counter is built and `timeout_o` is tied to 0.

## Test plan
- **Single request:** requester 1 requests vaddr 0x1000_0000 with QPN 0x11.
  - Expect `m_req_valid_o` at cycle +1 with the same vaddr and QPN.
  - Respond with paddr 0x8000_0000; expect `s_resp_valid_o` = 2'b10 with that paddr in `s_resp_data_o`.
- **Round-robin:** both requesters hold `s_req_valid_i` continuously and the table is always ready.
  - Expect grants in the order 0, 1, 0, 1.
  - Return 4 responses; expect them routed to 0, 1, 0, 1.
- **FIFO full:** `MAX_OUTSTANDING` = 4 and no responses are returned.
  - Expect exactly 4 issues, then `s_req_ready_o` = 0 and `outstanding_o` = 4.
  - One response frees one slot; expect exactly one new grant.
- **Response backpressure:** the head requester holds `s_resp_ready_i` = 0 for 5 cycles.
  - Expect `m_resp_ready_o` = 0 during those cycles and no pop.
  - Expect the same data delivered when ready rises.
- **Stray response:** `m_resp_valid_i` = 1 with the FIFO empty.
  - Expect `m_resp_ready_o` = 0 and no `s_resp_valid_o` bit set.
  - Assert reset mid-`ARB_HOLD`; expect every output at its reset value.
- **Watchdog (macro defined):** `TIMEOUT_CYCLES` = 16, one request outstanding, no response.
  - Expect `timeout_o` = 1 at cycle 16 and still 1 after a later response.
  - With the macro undefined, `timeout_o` stays 0.
